// File: rtl/nrzi_rx_destuff.sv
// NRZI receive decoder: line decode, stuff-bit removal and LSB-first word assembly,
// with one-cycle stuffing and framing error pulses.
module nrzi_rx_destuff #(
  parameter int   STUFF_LEN  = 6,
  parameter int   BYTE_W     = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  input  logic              line_valid,
  input  logic              frame_start,
  input  logic              frame_end,
  output logic [BYTE_W-1:0] data_out,
  output logic              byte_valid,
  output logic              stuff_err,
  output logic              partial_err,
  output logic              busy
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RECV = 1'b1;

  logic              state;
  logic              prev_line;
  logic [RUN_W-1:0]  zero_run;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shreg;

  logic              d;
  logic              stuff_fail;
  logic              word_done;
  logic [RUN_W-1:0]  zero_run_n;
  logic [CNT_W-1:0]  bit_cnt_n;
  logic [BYTE_W-1:0] shreg_n;

  assign d = line_in ^ prev_line;

  // Next-state of the receive datapath for the bit arriving this cycle
  always_comb begin
    zero_run_n = zero_run;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    word_done  = 1'b0;
    stuff_fail = 1'b0;
    if (state == S_RECV && line_valid) begin
      if (zero_run == RUN_W'(STUFF_LEN)) begin
        if (d) zero_run_n = '0;
        else   stuff_fail = 1'b1;
      end else begin
        shreg_n[bit_cnt] = d;
        zero_run_n       = d ? '0 : zero_run + RUN_W'(1);
        if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
          word_done = 1'b1;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      prev_line   <= IDLE_LEVEL;
      zero_run    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      byte_valid  <= 1'b0;
      stuff_err   <= 1'b0;
      partial_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      stuff_err   <= 1'b0;
      partial_err <= 1'b0;
      if (line_valid) prev_line <= line_in;

      // frame_start overrides everything else, including a coincident bit or frame_end
      if (frame_start) begin
        state    <= S_RECV;
        busy     <= 1'b1;
        zero_run <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
      end else if (state == S_RECV) begin
        if (stuff_fail) begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          stuff_err <= 1'b1;
          zero_run  <= '0;
          bit_cnt   <= '0;
          shreg     <= '0;
        end else begin
          zero_run <= zero_run_n;
          bit_cnt  <= bit_cnt_n;
          shreg    <= shreg_n;
          if (word_done) begin
            data_out   <= shreg_n;
            byte_valid <= 1'b1;
          end
          if (frame_end) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            partial_err <= (bit_cnt_n != '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nrzi_rx_destuff.sv
// Directed bench for nrzi_rx_destuff: bits are NRZI-encoded by the bench and
// decoded words, pulses and busy are compared against hand-computed values.
module tb_nrzi_rx_destuff;

  localparam int BYTE_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_in;
  logic              line_valid;
  logic              frame_start;
  logic              frame_end;
  logic [BYTE_W-1:0] data_out;
  logic              byte_valid;
  logic              stuff_err;
  logic              partial_err;
  logic              busy;

  int   tests = 0;
  int   fails = 0;
  logic line_lvl;

  nrzi_rx_destuff #(.STUFF_LEN(6), .BYTE_W(BYTE_W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .line_in(line_in), .line_valid(line_valid),
    .frame_start(frame_start), .frame_end(frame_end), .data_out(data_out),
    .byte_valid(byte_valid), .stuff_err(stuff_err), .partial_err(partial_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of stimulus; d is the data bit, NRZI-encoded onto the line here.
  task automatic step(input logic lv, input logic d, input logic fs, input logic fe);
    if (lv) line_lvl = line_lvl ^ d;
    line_valid  = lv;
    line_in     = line_lvl;
    frame_start = fs;
    frame_end   = fe;
    @(posedge clk); #1;
    line_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic send_word(input logic [BYTE_W-1:0] w, input logic fe_last, input int gap,
                           output int bv_cnt, output int err_cnt);
    bv_cnt  = 0;
    err_cnt = 0;
    for (int i = 0; i < BYTE_W; i++) begin
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        bv_cnt  += int'(byte_valid);
        err_cnt += int'(stuff_err) + int'(partial_err);
      end
      step(1'b1, w[i], 1'b0, fe_last && (i == BYTE_W - 1));
      bv_cnt  += int'(byte_valid);
      err_cnt += int'(stuff_err) + int'(partial_err);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; line_lvl = 1'b0; line_in = 1'b0;
    line_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; line_lvl = 1'b0; line_in = 1'b0;
    line_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    #2;
    tests++;
    if ({data_out, byte_valid, stuff_err, partial_err, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0", {data_out, byte_valid, stuff_err, partial_err, busy});
    end
    do_reset();
  endtask

  task automatic test_word_a5();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL a5_busy: got %b, expected 1", busy); end
    send_word(8'hA5, 1'b0, 0, bv, er);
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'hA5 || bv != 1 || er != 0) begin
      fails++;
      $display("FAIL a5_word: bv=%b data=%h pulses=%0d errs=%0d, expected bv=1 data=a5 pulses=1 errs=0", byte_valid, data_out, bv, er);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (byte_valid !== 1'b0 || data_out !== 8'hA5) begin
      fails++;
      $display("FAIL a5_hold: bv=%b data=%h, expected bv=0 data=a5", byte_valid, data_out);
    end
  endtask

  task automatic test_stuff_zero();
    logic [8:0] bits = 9'b001000000;   // six 0s, stuffed 1, two 0s (bit 0 first)
    int bv = 0;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      bv += int'(byte_valid) + int'(stuff_err);
    end
    tests++;
    if (bv != 0) begin fails++; $display("FAIL stuff0_early: pulses=%0d, expected 0", bv); end
    step(1'b1, bits[8], 1'b0, 1'b0);
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'h00 || stuff_err !== 1'b0) begin
      fails++;
      $display("FAIL stuff0_word: bv=%b data=%h serr=%b, expected bv=1 data=00 serr=0", byte_valid, data_out, stuff_err);
    end
  endtask

  task automatic test_stuff_violation();
    int bv = 0;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      bv += int'(byte_valid) + int'(stuff_err);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (stuff_err !== 1'b1 || busy !== 1'b0 || byte_valid !== 1'b0 || bv != 0) begin
      fails++;
      $display("FAIL stuff_violation: serr=%b busy=%b bv=%b early=%0d, expected serr=1 busy=0 bv=0 early=0", stuff_err, busy, byte_valid, bv);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (stuff_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stuff_pulse_len: serr=%b busy=%b, expected 0 0", stuff_err, busy);
    end
  endtask

  task automatic test_partial();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (partial_err !== 1'b1 || busy !== 1'b0 || byte_valid !== 1'b0) begin
      fails++;
      $display("FAIL partial_err: perr=%b busy=%b bv=%b, expected 1 0 0", partial_err, busy, byte_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (partial_err !== 1'b0) begin fails++; $display("FAIL partial_pulse_len: perr=%b, expected 0", partial_err); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 1'b1, 0, bv, er);
    tests++;
    if (byte_valid !== 1'b1 || partial_err !== 1'b0 || busy !== 1'b0 || data_out !== 8'hA5) begin
      fails++;
      $display("FAIL end_on_8th: bv=%b perr=%b busy=%b data=%h, expected 1 0 0 a5", byte_valid, partial_err, busy, data_out);
    end
  endtask

  task automatic test_gapped();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 1'b0, 2, bv, er);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bv += int'(byte_valid);
    tests++;
    if (bv != 1 || er != 0 || data_out !== 8'hA5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gapped: pulses=%0d errs=%0d data=%h busy=%b, expected 1 0 a5 1", bv, er, data_out, busy);
    end
  endtask

  task automatic test_back_to_back();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h03, 1'b0, 0, bv, er);   // ends with six 0s: a stuff bit follows
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'h03) begin
      fails++;
      $display("FAIL b2b_first: bv=%b data=%h, expected 1 03", byte_valid, data_out);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (byte_valid !== 1'b0 || stuff_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_stuff: bv=%b serr=%b busy=%b, expected 0 0 1", byte_valid, stuff_err, busy);
    end
    send_word(8'h5A, 1'b0, 0, bv, er);
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'h5A || bv != 1 || er != 0) begin
      fails++;
      $display("FAIL b2b_second: bv=%b data=%h pulses=%0d errs=%0d, expected 1 5a 1 0", byte_valid, data_out, bv, er);
    end
    // frame ends with a stuff bit still pending: no error expected
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h03, 1'b0, 0, bv, er);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (partial_err !== 1'b0 || stuff_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL pending_stuff_end: perr=%b serr=%b busy=%b, expected 0 0 0", partial_err, stuff_err, busy);
    end
  endtask

  task automatic test_restart();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);    // restart; this bit only moves prev_line
    tests++;
    if (partial_err !== 1'b0 || busy !== 1'b1 || byte_valid !== 1'b0) begin
      fails++;
      $display("FAIL restart: perr=%b busy=%b bv=%b, expected 0 1 0", partial_err, busy, byte_valid);
    end
    send_word(8'h3C, 1'b0, 0, bv, er);
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'h3C || bv != 1 || er != 0) begin
      fails++;
      $display("FAIL restart_word: bv=%b data=%h pulses=%0d errs=%0d, expected 1 3c 1 0", byte_valid, data_out, bv, er);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (busy !== 1'b1 || partial_err !== 1'b0) begin
      fails++;
      $display("FAIL start_end_same: busy=%b perr=%b, expected 1 0", busy, partial_err);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (busy !== 1'b0 || partial_err !== 1'b0) begin
      fails++;
      $display("FAIL empty_frame_end: busy=%b perr=%b, expected 0 0", busy, partial_err);
    end
  endtask

  task automatic test_reset_restart();
    int bv, er;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 1'b0, 0, bv, er);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);    // line left at 1 going into reset
    rst = 1'b1;
    #1;
    tests++;
    if ({data_out, byte_valid, stuff_err, partial_err, busy} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got %h, expected 0", {data_out, byte_valid, stuff_err, partial_err, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    line_lvl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({data_out, byte_valid, stuff_err, partial_err, busy} !== '0) begin
      fails++;
      $display("FAIL after_reset: got %h, expected 0", {data_out, byte_valid, stuff_err, partial_err, busy});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 0, bv, er);
    tests++;
    if (byte_valid !== 1'b1 || data_out !== 8'h3C || bv != 1 || er != 0) begin
      fails++;
      $display("FAIL reset_word_3c: bv=%b data=%h pulses=%0d errs=%0d, expected 1 3c 1 0", byte_valid, data_out, bv, er);
    end
  endtask

  initial begin
    test_reset();
    test_word_a5();
    test_stuff_zero();
    test_stuff_violation();
    test_partial();
    test_gapped();
    test_back_to_back();
    test_restart();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
